// File: rtl/anubis_pkg.sv
// ============================================================================
// anubis_pkg : shared Anubis key-schedule types and constants | Rev 1.0
// ============================================================================
`default_nettype none

package anubis_pkg;

  localparam int NR_128 = 12;

  // Round-constant seed mixed into the leading word of every schedule round.
  localparam logic [31:0] KS_RC_BASE = 32'h9E37_79B9;

  typedef logic [127:0] round_key_t;
  typedef logic [3:0]   round_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GEN  = 2'd1,
    ST_DONE = 2'd2
  } ks_state_e;

  // Map a logical round-key index onto the buffer; caller guarantees addr <= nr.
  function automatic round_idx_t phys_idx(input logic dir, input round_idx_t addr,
                                          input round_idx_t nr);
    return dir ? round_idx_t'(nr - addr) : addr;
  endfunction

endpackage

`default_nettype wire

// File: rtl/Key_Schedule.sv
// ============================================================================
// Key_Schedule : one combinational round of the Anubis key-evolution datapath | Rev 1.0
// ============================================================================
`default_nettype none

module Key_Schedule
  import anubis_pkg::*;
(
  input  round_key_t data_in,
  input  round_idx_t round_counter,
  output round_key_t data_out
);

  logic [127:0] rot;
  logic [31:0]  rc;
  logic [31:0]  w0, w1, w2, w3;

  // Byte rotation followed by a chained word XOR so every word depends on the constant.
  always_comb begin
    rot      = {data_in[119:0], data_in[127:120]};
    rc       = KS_RC_BASE ^ {28'h0, round_counter};
    w0       = rot[127:96] ^ rc;
    w1       = rot[95:64]  ^ w0;
    w2       = rot[63:32]  ^ w1;
    w3       = rot[31:0]   ^ w2;
    data_out = {w0, w1, w2, w3};
  end

endmodule

`default_nettype wire

// File: rtl/anubis_key_sched_ctrl.sv
// ============================================================================
// anubis_key_sched_ctrl : expands one 128-bit key into NR+1 buffered round keys | Rev 1.0
// ============================================================================
`default_nettype none

module anubis_key_sched_ctrl
  import anubis_pkg::*;
#(
  parameter int NR = NR_128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic         dir,
  input  logic [3:0]   rk_rd_addr,
  output logic [127:0] rk_rd_data,
  output logic         keys_valid,
  output logic         busy
);

  localparam round_idx_t NR_IDX = round_idx_t'(NR);

  ks_state_e  state_q, state_d;
  round_idx_t cnt_q, cnt_d;
  round_key_t ks_state_q, ks_state_d;
  logic       keys_valid_q, keys_valid_d;
  round_key_t rk_rd_data_q, rk_rd_data_d;
  round_key_t rk_q [0:NR];
  round_key_t rk_d [0:NR];
  round_key_t ks_out;
  round_idx_t rd_idx;

  Key_Schedule u_key_schedule (
    .data_in       (ks_state_q),
    .round_counter (cnt_q),
    .data_out      (ks_out)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ks_state_d   = ks_state_q;
    keys_valid_d = keys_valid_q;
    rk_d         = rk_q;
    key_ready    = 1'b0;
    busy         = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        key_ready = 1'b1;
        if (key_valid) begin
          ks_state_d   = key_in;
          cnt_d        = '0;
          keys_valid_d = 1'b0;
          state_d      = ST_GEN;
        end
      end
      ST_GEN: begin
        busy       = 1'b1;
        rk_d[cnt_q] = ks_out;
        ks_state_d = ks_out;
        if (cnt_q == NR_IDX) begin
          // cnt parks at NR so it never walks past the last buffer slot.
          keys_valid_d = 1'b1;
          state_d      = ST_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Out-of-range addresses never reach the subtraction or the array index.
  always_comb begin
    rd_idx       = '0;
    rk_rd_data_d = '0;
    if (keys_valid_q && (rk_rd_addr <= NR_IDX)) begin
      rd_idx       = phys_idx(dir, rk_rd_addr, NR_IDX);
      rk_rd_data_d = rk_q[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      ks_state_q   <= '0;
      keys_valid_q <= 1'b0;
      rk_rd_data_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ks_state_q   <= ks_state_d;
      keys_valid_q <= keys_valid_d;
      rk_rd_data_q <= rk_rd_data_d;
    end
  end

  // Buffer is deliberately left uncleared; keys_valid masks stale contents.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rk_q <= rk_d;
    end
  end

  assign keys_valid = keys_valid_q;
  assign rk_rd_data = rk_rd_data_q;

endmodule

`default_nettype wire
